// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding LOAD/STORE sequencer between the core and a handshake memory,
// with a bounded wait on mem_ack and a sticky timeout flag.
module data_mem_ctrl #(
  parameter int addr_width     = 16,
  parameter int data_width     = 32,
  parameter int reg_sel_width  = 3,
  parameter int timeout_cycles = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [addr_width-1:0]    req_addr,
  input  logic [data_width-1:0]    req_wdata,
  input  logic [reg_sel_width-1:0] req_dst,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [addr_width-1:0]    mem_addr,
  output logic [data_width-1:0]    mem_wdata,
  input  logic [data_width-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic                     wb_en,
  output logic [reg_sel_width-1:0] wb_dst,
  output logic [data_width-1:0]    wb_data,
  output logic                     err,
  input  logic                     err_clr
);
  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] LAST = CW'(timeout_cycles - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [addr_width-1:0]    addr_q, addr_d;
  logic [data_width-1:0]    wdata_q, wdata_d;
  logic [reg_sel_width-1:0] dst_q, dst_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [reg_sel_width-1:0] wb_dst_q, wb_dst_d;
  logic [data_width-1:0]    wb_data_q, wb_data_d;
  logic                     timeout;
  // mem_ack in the terminal cycle wins over the timeout
  assign timeout = (state_q == ACCESS) && !mem_ack && (cnt_q == LAST);
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    if (state_q == IDLE && req_valid) begin
      state_d = ACCESS;
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      dst_d   = req_dst;
      cnt_d   = '0;
    end else if (state_q == ACCESS) begin
      if (mem_ack) begin
        state_d = write_q ? IDLE : WB;
        if (!write_q) begin
          wb_data_d = mem_rdata;
          wb_dst_d  = dst_q;
        end
      end else if (timeout) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == WB) begin
      state_d = IDLE;
    end
    err_d = timeout | (err_q & ~err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
    end
  end
  assign busy      = (state_q != IDLE) || req_valid;
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & write_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign wb_en     = (state_q == WB);
  assign wb_dst    = wb_dst_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random transactions against a transaction-level model that
// predicts cycle counts, writeback values and the err flag from the access rules.
module tb_data_mem_ctrl;
  localparam int T = 16;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_write = 0;
  logic [15:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [2:0]  req_dst = 0;
  logic        busy, mem_req, mem_we, mem_ack = 0, wb_en, err, err_clr = 0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0, wb_data;
  logic [2:0]  wb_dst;
  int          n_checks = 0, n_err = 0;
  logic [2:0]  last_dst = 0;
  logic [31:0] last_data = 0;
  bit          err_m = 0;

  data_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_dst(req_dst), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_en(wb_en), .wb_dst(wb_dst),
    .wb_data(wb_data), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction: memory acks after w wait cycles (w >= T means never).
  task automatic op(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [2:0] dst,
                    input int w, input logic [31:0] rd, input bit clr, input bit rv_wb);
    int nbusy = 0, nreq = 0, nwb = 0;
    bit ok_bus = 1, done = 0;
    bit success = (w < T);
    int exp_req = success ? w + 1 : T;
    int exp_wb = (success && !wr) ? 1 : 0;
    int exp_busy = 1 + exp_req + exp_wb;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      req_valid = (i == 0);
      req_write = (i == 0) ? wr : 1'($urandom);
      req_addr  = (i == 0) ? a : 16'($urandom);
      req_wdata = (i == 0) ? d : $urandom;
      req_dst   = (i == 0) ? dst : 3'($urandom);
      err_clr = 0;
      #1;
      if (i > 0 && !busy) done = 1;
      else begin
        if (busy) nbusy++;
        if (mem_req) begin
          nreq++;
          if (mem_we !== wr || mem_addr !== a || mem_wdata !== d) ok_bus = 0;
          mem_ack = (nreq - 1 == w);
          mem_rdata = mem_ack ? rd : $urandom;
          err_clr = clr;
        end else begin
          if (mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0) ok_bus = 0;
          mem_ack = 1'($urandom);
          mem_rdata = $urandom;
        end
        if (wb_en) begin
          nwb++;
          check("wb_dst_at_wb", wb_dst, dst);
          check("wb_data_at_wb", wb_data, rd);
          if (rv_wb) req_valid = 1;
        end
      end
    end
    mem_ack = 0;
    check("op_done", done, 1);
    check("busy_cycles", nbusy, exp_busy);
    check("req_cycles", nreq, exp_req);
    check("wb_count", nwb, exp_wb);
    check("bus_values", ok_bus, 1);
    if (exp_wb == 1) begin
      last_dst = dst;
      last_data = rd;
    end
    err_m = !success ? 1 : (clr ? 0 : err_m);
    check("err_after", err, err_m);
    check("wb_dst_hold", wb_dst, last_dst);
    check("wb_data_hold", wb_data, last_data);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    #1;
    err_m = 0;
    check("err_cleared", err, 0);
  endtask

  initial begin
    bit wb_seen;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_err", err, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    req_valid = 1;
    #1;
    check("rst_busy_follows", busy, 1);
    req_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    op(1, 16'h0040, 32'hDEADBEEF, 3'd0, 0, 32'h0, 0, 0);
    op(0, 16'h1234, 32'h0, 3'd5, 3, 32'h000000A5, 0, 0);
    op(0, 16'h2000, 32'h0, 3'd2, 1000, 32'h0, 0, 0);
    pulse_clr();
    op(0, 16'h3000, 32'h0, 3'd1, T - 1, 32'h55AA55AA, 0, 0);
    op(1, 16'h3004, 32'h1, 3'd1, T, 32'h0, 1, 0);
    op(0, 16'h3008, 32'h0, 3'd7, 2, 32'h77, 1, 1);

    // back-to-back STORE then LOAD, zero-wait memory, req_valid held
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 16'hAAAA; req_wdata = 32'h11112222; req_dst = 0;
    mem_ack = 1;
    #1 check("b2b_issue_busy", busy, 1);
    @(negedge clk);
    req_write = 0; req_addr = 16'hBBBB; req_dst = 3'd6; mem_rdata = 32'hCAFEF00D;
    #1;
    check("b2b_st_req", mem_req, 1);
    check("b2b_st_we", mem_we, 1);
    check("b2b_st_addr_stable", mem_addr, 16'hAAAA);
    @(negedge clk);
    #1;
    check("b2b_gap_req", mem_req, 0);
    check("b2b_gap_busy", busy, 1);
    @(negedge clk);
    #1;
    check("b2b_ld_req", mem_req, 1);
    check("b2b_ld_we", mem_we, 0);
    check("b2b_ld_addr", mem_addr, 16'hBBBB);
    req_valid = 0;
    @(negedge clk);
    #1;
    check("b2b_wb_en", wb_en, 1);
    check("b2b_wb_data", wb_data, 32'hCAFEF00D);
    check("b2b_wb_dst", wb_dst, 3'd6);
    mem_ack = 0;
    last_dst = 3'd6;
    last_data = 32'hCAFEF00D;
    @(negedge clk);
    #1 check("b2b_idle", busy, 0);

    // reset in the middle of a LOAD access
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 16'h4444; req_dst = 3'd3;
    @(negedge clk);
    req_valid = 0;
    #1 check("mid_req_before", mem_req, 1);
    rst_n = 0;
    #1;
    check("mid_req_drop", mem_req, 0);
    check("mid_addr_zero", mem_addr, 0);
    check("mid_busy", busy, 0);
    check("mid_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    last_dst = 0;
    last_data = 0;
    err_m = 0;
    wb_seen = 0;
    mem_ack = 1;
    mem_rdata = 32'h99;
    repeat (5) begin
      @(negedge clk);
      #1 if (wb_en) wb_seen = 1;
    end
    mem_ack = 0;
    check("mid_no_wb", wb_seen, 0);
    check("mid_err_after", err, 0);
    check("mid_wb_data", wb_data, 0);

    for (int k = 0; k < 40; k++) begin
      int w;
      w = ($urandom % 4 == 0) ? int'($urandom_range(T - 2, T + 3)) : int'($urandom_range(0, 5));
      op(1'($urandom), 16'($urandom), $urandom, 3'($urandom), w, $urandom,
         ($urandom % 4) == 0, 1'($urandom));
      if ($urandom % 6 == 0) pulse_clr();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
